prog_loader: RTL and testbench

- Front-end stage that fills the tiny CPU's 32-byte instruction/data memory before execution.
- Bytes arrive over a slow pin-level strobe/data interface. The loader synchronises the strobe, frames the transfer as length + payload + checksum, and writes the payload sequentially into memory through a write port.
- It holds the CPU in reset while loading and releases it only after a good checksum.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_sync_edge_det.sv | 38 +++
 rtl/prog_loader.sv | 165 ++++++++++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader and the tiny CPU core:
//   - default memory geometry (depth / address width)
//   - loader state encoding
//   - status codes presented on the loader's status port
// ---------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int LDR_MEM_DEPTH = 32;
  localparam int LDR_ADDR_W    = $clog2(LDR_MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_READY = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } ldr_state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

endpackage

// File: rtl/prog_loader_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchroniser for an asynchronous pin, plus a one-cycle pulse on
// the synchronised rising edge.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (clears all flops)
//   din    in   asynchronous pin input
//   level  out  synchronised level (after two flops)
//   rise   out  high for one cycle when level goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      // metastability stage -> settled stage -> one-cycle history
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~sync_p2;

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Fills the CPU's instruction/data memory from a slow pin-level byte
// interface before execution. A transfer is framed as
//   length byte L (1..MEM_DEPTH), L payload bytes, XOR checksum byte.
// Payload is written sequentially from address 0. The CPU is held in reset
// while loading and released only after a good checksum and load_mode low.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_mode           async request to enter load mode (level)
//   load_strobe         async byte strobe, byte taken on its rising edge
//   load_data[7:0]      byte on pins, stable around the strobe
//   mem_we/addr/wdata   one-cycle memory write port
//   cpu_rst_n           low = CPU held at PC 0
//   status[1:0]         0 IDLE, 1 LOADING, 2 READY/RUN, 3 ERROR
//   byte_cnt            payload bytes written in the current load
// ---------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_DEPTH = LDR_MEM_DEPTH,
  parameter int ADDR_W    = LDR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              load_strobe,
  input  logic [7:0]        load_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic [1:0]        status,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam logic [7:0]      MAX_LEN = 8'(MEM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  ldr_state_t      state;
  logic [ADDR_W:0] len;
  logic [7:0]      csum;
  logic [ADDR_W:0] cnt_next;

  logic mode, mode_rise_unused;
  logic strb_evt, strb_level_unused;

  // Mode is only ever looked at as a level; the strobe only as an edge.
  sync_edge_det u_sync_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (load_mode),
    .level (mode),
    .rise  (mode_rise_unused)
  );

  sync_edge_det u_sync_strobe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (load_strobe),
    .level (strb_level_unused),
    .rise  (strb_evt)
  );

  assign cnt_next = byte_cnt + CNT_ONE;

  // load_data is sampled only on a synchronised strobe event, by which time
  // the pins have been stable for at least two clocks. len, csum and
  // mem_wdata act as the holding registers for the captured byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      status    <= ST_IDLE;
      byte_cnt  <= '0;
      csum      <= '0;
      len       <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          cpu_rst_n <= 1'b0;
          status    <= ST_IDLE;
          if (mode) begin
            state  <= S_LEN;
            status <= ST_LOADING;
          end
        end
        S_LEN: begin
          if (!mode) begin
            state  <= S_ERROR;
            status <= ST_ERROR;
          end else if (strb_evt) begin
            if (load_data == 8'd0 || load_data > MAX_LEN) begin
              state  <= S_ERROR;
              status <= ST_ERROR;
            end else begin
              len      <= load_data[ADDR_W:0];
              byte_cnt <= '0;
              csum     <= '0;
              state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (!mode) begin
            state  <= S_ERROR;
            status <= ST_ERROR;
          end else if (strb_evt) begin
            mem_we    <= 1'b1;
            mem_addr  <= byte_cnt[ADDR_W-1:0];
            mem_wdata <= load_data;
            byte_cnt  <= cnt_next;
            csum      <= csum ^ load_data;
            // L <= MEM_DEPTH, so the last address written is L-1: no wrap.
            if (cnt_next == len) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!mode) begin
            state  <= S_ERROR;
            status <= ST_ERROR;
          end else if (strb_evt) begin
            if (load_data == csum) begin
              state  <= S_READY;
              status <= ST_READY;
            end else begin
              state  <= S_ERROR;
              status <= ST_ERROR;
            end
          end
        end
        S_READY: begin
          if (!mode) begin
            state     <= S_RUN;
            cpu_rst_n <= 1'b1;
          end
        end
        S_RUN: begin
          if (mode) begin
            state     <= S_LEN;
            cpu_rst_n <= 1'b0;
            status    <= ST_LOADING;
          end
        end
        S_ERROR: begin
          cpu_rst_n <= 1'b0;
          if (!mode) begin
            state  <= S_IDLE;
            status <= ST_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          status    <= ST_IDLE;
          cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed and randomized loads against a transaction-level model of the
// loader: a load of (L, payload, checksum) must produce exactly L writes at
// addresses 0..L-1 with the payload bytes and end READY iff L is legal and
// the checksum equals the XOR of the payload.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       load_mode;
  logic       load_strobe;
  logic [7:0] load_data;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst_n;
  logic [1:0] status;
  logic [5:0] byte_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] pay_q[$];

  prog_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_mode   (load_mode),
    .load_strobe (load_strobe),
    .load_data   (load_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_rst_n   (cpu_rst_n),
    .status      (status),
    .byte_cnt    (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed write transactions, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) load_data = b;
    @(negedge clk) load_strobe = 1'b1;
    repeat (4) @(negedge clk);
    load_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter_load(input string tag);
    @(negedge clk) load_mode = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, "_enter_status"}, status, 2'd1);
    chk({tag, "_enter_crst"}, cpu_rst_n, 1'b0);
  endtask

  task automatic leave_load(input string tag, input logic [1:0] st_exp, input logic crst_exp);
    @(negedge clk) load_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_leave_status"}, status, st_exp);
    chk({tag, "_leave_crst"}, cpu_rst_n, crst_exp);
  endtask

  // Model: legal L gives L writes of pay_q at 0..L-1; READY iff ck == XOR.
  task automatic run_load(input logic [7:0] len, input logic [7:0] ck,
                          input string tag, output bit good);
    logic [7:0] x;
    int         n_exp;
    logic [1:0] st_exp;
    bit         ok_len;
    ok_len = (len != 8'd0) && (len <= 8'd32);
    x = 8'h00;
    foreach (pay_q[i]) x ^= pay_q[i];
    n_exp  = ok_len ? int'(len) : 0;
    good   = ok_len && (ck == x);
    st_exp = good ? 2'd2 : 2'd3;
    wa_q.delete();
    wd_q.delete();
    send_byte(len);
    if (ok_len) begin
      foreach (pay_q[i]) send_byte(pay_q[i]);
      send_byte(ck);
    end
    chk({tag, "_status"}, status, st_exp);
    chk({tag, "_nwr"}, wa_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, wa_q[i], i);
      chk({tag, "_data"}, wd_q[i], pay_q[i]);
    end
    if (ok_len) chk({tag, "_byte_cnt"}, byte_cnt, len);
    chk({tag, "_crst"}, cpu_rst_n, 1'b0);
  endtask

  initial begin
    bit         good;
    logic [7:0] x;
    logic [7:0] ck;
    int         len;
    int         pulses;
    int         we_edge;

    rst_n = 1'b0;
    load_mode = 1'b0;
    load_strobe = 1'b0;
    load_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 5'd0);
    chk("rst_mem_wdata", mem_wdata, 8'd0);
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_status", status, 2'd0);
    chk("rst_byte_cnt", byte_cnt, 6'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_status", status, 2'd0);

    // Good 3-byte load, then release the CPU.
    enter_load("l3");
    pay_q = '{8'h41, 8'h82, 8'hC3};
    run_load(8'd3, 8'h00, "l3", good);
    leave_load("l3", 2'd2, 1'b1);

    // Reload from RUN: CPU reset falls on the third edge after the pin.
    @(negedge clk) load_mode = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reload_crst_hold", cpu_rst_n, 1'b1);
    @(posedge clk); #1;
    chk("reload_crst_fall", cpu_rst_n, 1'b0);
    repeat (2) @(negedge clk);
    chk("reload_status", status, 2'd1);
    pay_q = '{8'h55};
    run_load(8'd1, 8'h55, "l1", good);
    leave_load("l1", 2'd2, 1'b1);

    // Bad checksum.
    enter_load("bad");
    pay_q = '{8'h10, 8'h20};
    run_load(8'd2, 8'h31, "bad", good);
    leave_load("bad", 2'd0, 1'b0);

    // Illegal lengths.
    enter_load("len0");
    pay_q.delete();
    run_load(8'd0, 8'h00, "len0", good);
    leave_load("len0", 2'd0, 1'b0);
    enter_load("len33");
    run_load(8'd33, 8'h00, "len33", good);
    leave_load("len33", 2'd0, 1'b0);

    // Full memory, data = address index (XOR of 0..31 is 0).
    enter_load("full");
    pay_q.delete();
    for (int i = 0; i < 32; i++) pay_q.push_back(8'(i));
    run_load(8'd32, 8'h00, "full", good);
    chk("full_last_addr", mem_addr, 5'd31);
    leave_load("full", 2'd2, 1'b1);

    // Randomized loads with correct or single-bit-corrupted checksums.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 32);
      pay_q.delete();
      x = 8'h00;
      for (int j = 0; j < len; j++) begin
        pay_q.push_back(8'($urandom_range(0, 255)));
        x ^= pay_q[j];
      end
      ck = ($urandom_range(0, 1) == 1) ? x : (x ^ (8'h01 << $urandom_range(0, 7)));
      enter_load("rnd");
      run_load(8'(len), ck, "rnd", good);
      leave_load("rnd", good ? 2'd2 : 2'd0, good);
    end

    // Long strobe during DATA: one write, three edges after the rise.
    enter_load("held");
    send_byte(8'd2);
    @(negedge clk) load_data = 8'hA5;
    @(negedge clk) load_strobe = 1'b1;
    pulses = 0;
    we_edge = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (mem_we === 1'b1) begin
        pulses++;
        we_edge = k;
      end
    end
    load_strobe = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_pulses", pulses, 1);
    chk("held_edge", we_edge, 3);
    chk("held_byte_cnt", byte_cnt, 6'd1);
    chk("held_wdata", mem_wdata, 8'hA5);

    // Asynchronous reset mid-DATA.
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_we", mem_we, 1'b0);
    chk("arst_mem_addr", mem_addr, 5'd0);
    chk("arst_mem_wdata", mem_wdata, 8'd0);
    chk("arst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("arst_status", status, 2'd0);
    chk("arst_byte_cnt", byte_cnt, 6'd0);
    load_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_status", status, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
